// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold counter.
// Define RR_ARBITER_PREEMPT_EN to force the grant on after MAX_HOLD cycles.
module rr_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] id_q, id_d;
    logic          busy_q, busy_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [HW-1:0] hold_inc;
    logic [IW-1:0] next_ptr;
    logic [IW:0]   win_idle;
    logic [IW:0]   win_move;

    // Returns {found, index} of the first set bit searching from base upward.
    function automatic logic [IW:0] pick(input logic [N-1:0] req,
                                         input logic [IW-1:0] base);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(base) + i) % N;
            if (req[j]) begin
                res = {1'b1, IW'(j)};
            end
        end
        return res;
    endfunction

    assign next_ptr = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
    assign hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    assign win_idle = pick(request, ptr_q);
    // Owner sits last in this order, so it only wins back if nobody else asks.
    assign win_move = pick(request, next_ptr);

`ifdef RR_ARBITER_PREEMPT_EN
    logic          preempt_q, preempt_d;
    logic [N-1:0]  others;
    assign others = request & ~grant_q;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
`ifdef RR_ARBITER_PREEMPT_EN
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_idle[IW]) begin
                    state_d = OWNED;
                    grant_d = N'(1) << win_idle[IW-1:0];
                    id_d    = win_idle[IW-1:0];
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            OWNED: begin
                if (!request[id_q]) begin
                    ptr_d  = next_ptr;
                    hold_d = '0;
                    if (win_move[IW]) begin
                        grant_d = N'(1) << win_move[IW-1:0];
                        id_d    = win_move[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        busy_d  = 1'b0;
                    end
`ifdef RR_ARBITER_PREEMPT_EN
                end else if (hold_inc == HW'(MAX_HOLD) && |others) begin
                    ptr_d     = next_ptr;
                    hold_d    = '0;
                    grant_d   = N'(1) << win_move[IW-1:0];
                    id_d      = win_move[IW-1:0];
                    preempt_d = 1'b1;
`endif
                end else begin
                    hold_d = hold_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

`ifdef RR_ARBITER_PREEMPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= preempt_d;
        end
    end
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: an N=2 and an N=4 instance against a
// behavioural owner/pointer model, with directed and random stimulus.
module tb_rr_arbiter;

`ifdef RR_ARBITER_PREEMPT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] req2;
    logic [3:0] req4;
    logic [1:0] g2;
    logic [0:0] id2;
    logic       b2, p2;
    logic [3:0] g4;
    logic [1:0] id4;
    logic       b4, p4;

    int vec  = 0;
    int miss = 0;

    int NN[2] = '{2, 4};
    int MH[2] = '{4, 3};
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];
    bit m_pre[2];

    rr_arbiter #(.N(2), .MAX_HOLD(4)) u2 (
        .clk(clk), .rst_n(rst_n), .request(req2),
        .grant(g2), .grant_id(id2), .busy(b2), .preempt(p2)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(3)) u4 (
        .clk(clk), .rst_n(rst_n), .request(req4),
        .grant(g4), .grant_id(id4), .busy(b4), .preempt(p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first(input logic [3:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_held[d]  = 0;
            m_pre[d]   = 1'b0;
        end
    endfunction

    // Cycles-held count includes the cycle the grant was issued in.
    function automatic void model_step(input int d, input logic [3:0] r);
        int n;
        int o;
        n = NN[d];
        o = m_owner[d];
        m_pre[d] = 1'b0;
        if (o < 0) begin
            if (r != 0) begin
                m_owner[d] = first(r, m_ptr[d], n);
                m_held[d]  = 1;
            end
        end else if (!r[o]) begin
            m_ptr[d]   = (o + 1) % n;
            m_owner[d] = first(r, m_ptr[d], n);
            m_held[d]  = 1;
        end else if (PE && m_held[d] >= MH[d] && (r & ~(4'b0001 << o)) != 0) begin
            m_ptr[d]   = (o + 1) % n;
            m_owner[d] = first(r & ~(4'b0001 << o), m_ptr[d], n);
            m_held[d]  = 1;
            m_pre[d]   = 1'b1;
        end else begin
            m_held[d]++;
        end
    endfunction

    function automatic logic [7:0] act(input int d);
        if (d == 0) return {2'b00, g2, 1'b0, id2, b2, p2};
        return {g4, id4, b4, p4};
    endfunction

    function automatic logic [7:0] expv(input int d);
        logic [7:0] e;
        e = '0;
        if (m_owner[d] >= 0) begin
            e[7:4] = 4'b0001 << m_owner[d];
            e[3:2] = 2'(m_owner[d]);
            e[1]   = 1'b1;
        end
        e[0] = m_pre[d];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, {2'b00, req2});
        model_step(1, req4);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req2  = 2'b11;
        req4  = 4'b1111;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            vec++;
            if (act(d) !== expv(d)) begin
                miss++;
                $display("FAIL reset dut%0d: got %b want %b", d, act(d), expv(d));
            end
        end
        req2  = 2'b00;
        req4  = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        req2 = 2'b11;
        tick();
        vec++;
        if ({g2, id2, b2} !== 4'b01_0_1) begin
            miss++;
            $display("FAIL simul_start: got g=%b id=%0d b=%b want g=01 id=0 b=1", g2, id2, b2);
        end
    endtask

    task automatic test_handoff();
        logic [1:0] want[3] = '{2'b10, 2'b00, 2'b01};
        logic [1:0] drv[3]  = '{2'b10, 2'b00, 2'b01};
        for (int s = 0; s < 3; s++) begin
            req2 = drv[s];
            tick();
            vec++;
            if (g2 !== want[s] || b2 !== (want[s] != 0)) begin
                miss++;
                $display("FAIL handoff step%0d: got g=%b b=%b want g=%b", s, g2, b2, want[s]);
            end
            vec++;
            if (act(0) !== expv(0)) begin
                miss++;
                $display("FAIL handoff_model step%0d: got %b want %b", s, act(0), expv(0));
            end
        end
    endtask

    task automatic test_ptr_order();
        logic [3:0] drv[4]  = '{4'b0010, 4'b0000, 4'b1010, 4'b0010};
        logic [3:0] want[4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0010};
        for (int s = 0; s < 4; s++) begin
            req4 = drv[s];
            tick();
            vec++;
            if (g4 !== want[s]) begin
                miss++;
                $display("FAIL ptr_order step%0d: got g=%b want g=%b", s, g4, want[s]);
            end
            vec++;
            if (act(1) !== expv(1)) begin
                miss++;
                $display("FAIL ptr_order_model step%0d: got %b want %b", s, act(1), expv(1));
            end
        end
    endtask

    task automatic test_hold_rotation();
        logic [1:0] wg;
        logic       wp;
        pulse_reset();
        req2 = 2'b11;
        req4 = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            wg = 2'b01;
            wp = 1'b0;
            if (PE) begin
                wg = (((c - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
                wp = (c > 1) && ((c - 1) % 4 == 0);
            end
            vec++;
            if (g2 !== wg || p2 !== wp) begin
                miss++;
                $display("FAIL hold_rot cyc%0d: got g=%b p=%b want g=%b p=%b", c, g2, p2, wg, wp);
            end
        end
    endtask

    task automatic test_solo_hold();
        pulse_reset();
        req2 = 2'b01;
        for (int c = 1; c <= 20; c++) begin
            tick();
            vec++;
            if (g2 !== 2'b01 || p2 !== 1'b0) begin
                miss++;
                $display("FAIL solo_hold cyc%0d: got g=%b p=%b want g=01 p=0", c, g2, p2);
            end
        end
    endtask

    task automatic test_reset_mid();
        req2 = 2'b01;
        req4 = 4'b0100;
        tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        vec++;
        if ({g2, b2, g4, b4, p2, p4} !== 10'b0) begin
            miss++;
            $display("FAIL reset_mid: got g2=%b b2=%b g4=%b b4=%b want all 0", g2, b2, g4, b4);
        end
        rst_n = 1'b1;
        req2  = 2'b10;
        req4  = 4'b0000;
        tick();
        vec++;
        if (g2 !== 2'b10 || id2 !== 1'b1 || b2 !== 1'b1) begin
            miss++;
            $display("FAIL reset_mid_regrant: got g=%b id=%0d want g=10 id=1", g2, id2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req2 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) req4 = 4'($urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                vec++;
                if (act(d) !== expv(d)) begin
                    miss++;
                    $display("FAIL random cyc%0d dut%0d: got %b want %b", c, d, act(d), expv(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_handoff();
        test_ptr_order();
        test_hold_rotation();
        test_solo_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
